// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter sharing the data cache request/response port between two requesters.
// Define DCACHE_ARB_STATS_EN to add saturating per-requester grant counters (m0/m1_grant_cnt).
module dcache_req_arbiter #(
    parameter int WORD_SIZE   = 8,
    parameter int ADDR_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   m0_req_valid,
    input  logic [ADDR_LENGTH-1:0] m0_req_addr,
    input  logic [WORD_SIZE-1:0]   m0_req_wdata,
    input  logic                   m0_req_write,
    input  logic [2:0]             m0_req_size,
    output logic                   m0_req_ready,
    output logic                   m0_resp_valid,
    output logic [WORD_SIZE-1:0]   m0_resp_rdata,
    input  logic                   m1_req_valid,
    input  logic [ADDR_LENGTH-1:0] m1_req_addr,
    input  logic [WORD_SIZE-1:0]   m1_req_wdata,
    input  logic                   m1_req_write,
    input  logic [2:0]             m1_req_size,
    output logic                   m1_req_ready,
    output logic                   m1_resp_valid,
    output logic [WORD_SIZE-1:0]   m1_resp_rdata,
    output logic                   c_req_valid,
    output logic [ADDR_LENGTH-1:0] c_req_addr,
    output logic [WORD_SIZE-1:0]   c_req_wdata,
    output logic                   c_req_write,
    output logic [2:0]             c_req_size,
    input  logic                   c_req_ready,
    input  logic                   c_resp_valid,
    input  logic [WORD_SIZE-1:0]   c_resp_rdata,
    output logic                   busy,
    output logic [1:0]             dbg_state,
    output logic                   owner
`ifdef DCACHE_ARB_STATS_EN
    ,
    output logic [7:0]             m0_grant_cnt,
    output logic [7:0]             m1_grant_cnt
`endif
);

    // Handshake: a request transfers on a cycle where valid and ready are both 1; the
    // requester holds valid and its fields stable until then. Responses are single-cycle pulses.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t r_state, w_next_state;
    logic   r_owner, w_next_owner;
    logic   r_last_grant, w_next_last_grant;
    logic   w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_owner      <= w_next_owner;
            r_last_grant <= w_next_last_grant;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_owner      = r_owner;
        w_next_last_grant = r_last_grant;
        w_done            = 1'b0;
        c_req_valid       = 1'b0;
        c_req_addr        = '0;
        c_req_wdata       = '0;
        c_req_write       = 1'b0;
        c_req_size        = '0;
        m0_req_ready      = 1'b0;
        m1_req_ready      = 1'b0;
        m0_resp_valid     = 1'b0;
        m1_resp_valid     = 1'b0;
        m0_resp_rdata     = '0;
        m1_resp_rdata     = '0;

        case (r_state)
            ST_IDLE: begin
                // On a tie the requester that did not complete last goes next.
                if (m0_req_valid && m1_req_valid) begin
                    w_next_owner = ~r_last_grant;
                    w_next_state = ST_ISSUE;
                end else if (m0_req_valid || m1_req_valid) begin
                    w_next_owner = m1_req_valid;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                c_req_valid  = 1'b1;
                c_req_addr   = r_owner ? m1_req_addr  : m0_req_addr;
                c_req_wdata  = r_owner ? m1_req_wdata : m0_req_wdata;
                c_req_write  = r_owner ? m1_req_write : m0_req_write;
                c_req_size   = r_owner ? m1_req_size  : m0_req_size;
                m0_req_ready = ~r_owner & c_req_ready;
                m1_req_ready = r_owner & c_req_ready;
                if (c_req_ready) begin
                    if (c_resp_valid) begin
                        w_done = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (c_resp_valid) begin
                    w_done = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (w_done) begin
            m0_resp_valid     = ~r_owner;
            m1_resp_valid     = r_owner;
            m0_resp_rdata     = r_owner ? '0 : c_resp_rdata;
            m1_resp_rdata     = r_owner ? c_resp_rdata : '0;
            w_next_last_grant = r_owner;
            w_next_state      = ST_IDLE;
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;
    assign owner     = r_owner;

`ifdef DCACHE_ARB_STATS_EN
    logic [7:0] r_m0_cnt, r_m1_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m0_cnt <= 8'd0;
            r_m1_cnt <= 8'd0;
        end else begin
            if (m0_req_ready && (r_m0_cnt != 8'd255)) r_m0_cnt <= r_m0_cnt + 8'd1;
            if (m1_req_ready && (r_m1_cnt != 8'd255)) r_m1_cnt <= r_m1_cnt + 8'd1;
        end
    end

    assign m0_grant_cnt = r_m0_cnt;
    assign m1_grant_cnt = r_m1_cnt;
`endif

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Self-checking bench for dcache_req_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_dcache_req_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_valid [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       req_write [2];
    logic [2:0] req_size  [2];
    logic       req_ready [2];
    logic       resp_valid[2];
    logic [7:0] resp_rdata[2];
    logic       c_req_valid, c_req_write, c_req_ready, c_resp_valid;
    logic [7:0] c_req_addr, c_req_wdata, c_resp_rdata;
    logic [2:0] c_req_size;
    logic       busy, owner;
    logic [1:0] dbg_state;
`ifdef DCACHE_ARB_STATS_EN
    logic [7:0] grant_cnt [2];
`endif

    dcache_req_arbiter #(.WORD_SIZE(8), .ADDR_LENGTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_valid (req_valid[0]),
        .m0_req_addr  (req_addr[0]),
        .m0_req_wdata (req_wdata[0]),
        .m0_req_write (req_write[0]),
        .m0_req_size  (req_size[0]),
        .m0_req_ready (req_ready[0]),
        .m0_resp_valid(resp_valid[0]),
        .m0_resp_rdata(resp_rdata[0]),
        .m1_req_valid (req_valid[1]),
        .m1_req_addr  (req_addr[1]),
        .m1_req_wdata (req_wdata[1]),
        .m1_req_write (req_write[1]),
        .m1_req_size  (req_size[1]),
        .m1_req_ready (req_ready[1]),
        .m1_resp_valid(resp_valid[1]),
        .m1_resp_rdata(resp_rdata[1]),
        .c_req_valid  (c_req_valid),
        .c_req_addr   (c_req_addr),
        .c_req_wdata  (c_req_wdata),
        .c_req_write  (c_req_write),
        .c_req_size   (c_req_size),
        .c_req_ready  (c_req_ready),
        .c_resp_valid (c_resp_valid),
        .c_resp_rdata (c_resp_rdata),
        .busy         (busy),
        .dbg_state    (dbg_state),
        .owner        (owner)
`ifdef DCACHE_ARB_STATS_EN
        ,
        .m0_grant_cnt (grant_cnt[0]),
        .m1_grant_cnt (grant_cnt[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a transaction is either absent, presented to the cache, or accepted
    // and waiting for its response.
    logic       mdl_active, mdl_accepted, mdl_owner, mdl_last;
    int         mdl_cnt [2];
    logic       nxt_active, nxt_accepted, nxt_owner, nxt_last;
    int         nxt_cnt [2];
    logic       exp_cv, exp_write;
    logic [7:0] exp_addr, exp_wdata;
    logic [2:0] exp_size;
    logic       exp_rdy [2];
    logic       exp_rv  [2];
    logic [7:0] exp_rd  [2];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_active   = 1'b0;
        mdl_accepted = 1'b0;
        mdl_owner    = 1'b0;
        mdl_last     = 1'b1;
        mdl_cnt[0]   = 0;
        mdl_cnt[1]   = 0;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = 8'h00;
            req_wdata[i] = 8'h00;
            req_write[i] = 1'b0;
            req_size[i]  = 3'd0;
        end
        c_req_ready  = 1'b0;
        c_resp_valid = 1'b0;
        c_resp_rdata = 8'h00;
    endtask

    task automatic finish_txn(input logic who);
        exp_rv[who]  = 1'b1;
        exp_rd[who]  = c_resp_rdata;
        nxt_active   = 1'b0;
        nxt_accepted = 1'b0;
        nxt_last     = who;
    endtask

    // At the falling edge: derive expected outputs from the model and current inputs, compare.
    task automatic eval();
        @(negedge clk);
        exp_cv = 1'b0; exp_addr = 8'h00; exp_wdata = 8'h00; exp_write = 1'b0; exp_size = 3'd0;
        for (int i = 0; i < 2; i++) begin
            exp_rdy[i] = 1'b0; exp_rv[i] = 1'b0; exp_rd[i] = 8'h00;
            nxt_cnt[i] = mdl_cnt[i];
        end
        nxt_active = mdl_active; nxt_accepted = mdl_accepted;
        nxt_owner = mdl_owner; nxt_last = mdl_last;
        if (!mdl_active) begin
            if (req_valid[0] && req_valid[1]) begin
                nxt_active = 1'b1;
                nxt_owner  = !mdl_last;
            end else if (req_valid[0] || req_valid[1]) begin
                nxt_active = 1'b1;
                nxt_owner  = req_valid[0] ? 1'b0 : 1'b1;
            end
        end else if (!mdl_accepted) begin
            exp_cv    = 1'b1;
            exp_addr  = req_addr[mdl_owner];
            exp_wdata = req_wdata[mdl_owner];
            exp_write = req_write[mdl_owner];
            exp_size  = req_size[mdl_owner];
            exp_rdy[mdl_owner] = c_req_ready;
            if (c_req_ready && c_resp_valid) finish_txn(mdl_owner);
            else if (c_req_ready) nxt_accepted = 1'b1;
        end else if (c_resp_valid) begin
            finish_txn(mdl_owner);
        end
        for (int i = 0; i < 2; i++)
            if (exp_rdy[i] && mdl_cnt[i] < 255) nxt_cnt[i] = mdl_cnt[i] + 1;

        chk("c_req_valid", c_req_valid, exp_cv);
        chk("c_req_addr", c_req_addr, exp_addr);
        chk("c_req_wdata", c_req_wdata, exp_wdata);
        chk("c_req_write", c_req_write, exp_write);
        chk("c_req_size", c_req_size, exp_size);
        chk("m0_req_ready", req_ready[0], exp_rdy[0]);
        chk("m1_req_ready", req_ready[1], exp_rdy[1]);
        chk("m0_resp_valid", resp_valid[0], exp_rv[0]);
        chk("m1_resp_valid", resp_valid[1], exp_rv[1]);
        chk("m0_resp_rdata", resp_rdata[0], exp_rd[0]);
        chk("m1_resp_rdata", resp_rdata[1], exp_rd[1]);
        chk("busy", busy, mdl_active);
        chk("owner", owner, mdl_owner);
`ifdef DCACHE_ARB_STATS_EN
        chk("m0_grant_cnt", grant_cnt[0], mdl_cnt[0]);
        chk("m1_grant_cnt", grant_cnt[1], mdl_cnt[1]);
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        mdl_active = nxt_active; mdl_accepted = nxt_accepted;
        mdl_owner = nxt_owner; mdl_last = nxt_last;
        mdl_cnt[0] = nxt_cnt[0]; mdl_cnt[1] = nxt_cnt[1];
    endtask

    task automatic cycle();
        eval();
        advance();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic w, input logic [7:0] d);
        req_valid[i] = 1'b1;
        req_addr[i]  = a;
        req_write[i] = w;
        req_wdata[i] = d;
        req_size[i]  = 3'd0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        // Reset values, with rst_n still low.
        @(negedge clk);
        chk("rst_c_req_valid", c_req_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_m0_ready", req_ready[0], 1'b0);
        chk("rst_c_req_addr", c_req_addr, 8'h00);
        do_reset();

        // Single read from m0, cache accepts next cycle, responds one cycle later.
        set_req(0, 8'h05, 1'b0, 8'h00);
        eval();
        chk("t1_idle_cv", c_req_valid, 1'b0);
        advance();
        c_req_ready = 1'b1;
        eval();
        chk("t1_issue_cv", c_req_valid, 1'b1);
        chk("t1_issue_addr", c_req_addr, 8'h05);
        chk("t1_m0_ready", req_ready[0], 1'b1);
        advance();
        req_valid[0] = 1'b0;
        c_req_ready = 1'b0;
        c_resp_valid = 1'b1;
        c_resp_rdata = 8'h69;
        eval();
        chk("t1_m0_resp_valid", resp_valid[0], 1'b1);
        chk("t1_m0_resp_rdata", resp_rdata[0], 8'h69);
        chk("t1_m1_resp_valid", resp_valid[1], 1'b0);
        advance();
        c_resp_valid = 1'b0;
        cycle();

        // Both requesters held valid from reset: grants must alternate starting with m0.
        do_reset();
        set_req(0, 8'h01, 1'b0, 8'h00);
        set_req(1, 8'h02, 1'b1, 8'h3C);
        c_req_ready = 1'b1;
        exp_q = {8'h01, 8'h02, 8'h01, 8'h02};
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            eval();
            if (exp_rdy[0] || exp_rdy[1]) chk("t2_grant_order", c_req_addr, exp_q.pop_front());
            advance();
            c_resp_valid = exp_rdy[0] || exp_rdy[1];
            c_resp_rdata = $urandom_range(0, 255);
        end
        chk("t2_all_grants_seen", exp_q.size(), 0);
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            c_resp_valid = mdl_accepted;
            cycle();
        end

        // Cache stalls for 4 cycles while m1's request is presented.
        clear_inputs();
        set_req(1, 8'h33, 1'b0, 8'h00);
        cycle();
        for (int k = 0; k < 4; k++) begin
            eval();
            chk("t3_stall_cv", c_req_valid, 1'b1);
            chk("t3_stall_addr", c_req_addr, 8'h33);
            chk("t3_stall_ready", req_ready[1], 1'b0);
            advance();
        end
        c_req_ready = 1'b1;
        eval();
        chk("t3_ready", req_ready[1], 1'b1);
        advance();
        clear_inputs();
        c_resp_valid = 1'b1;
        c_resp_rdata = 8'h11;
        cycle();
        c_resp_valid = 1'b0;

        // Zero-latency hit: accept and response in the same ISSUE cycle.
        set_req(0, 8'h44, 1'b0, 8'h00);
        cycle();
        c_req_ready = 1'b1;
        c_resp_valid = 1'b1;
        c_resp_rdata = 8'hA5;
        eval();
        chk("t4_m0_resp_valid", resp_valid[0], 1'b1);
        chk("t4_m0_resp_rdata", resp_rdata[0], 8'hA5);
        advance();
        clear_inputs();
        eval();
        chk("t4_busy_after", busy, 1'b0);
        advance();

        // Reset asserted while waiting for a response.
        set_req(1, 8'h77, 1'b0, 8'h00);
        cycle();
        c_req_ready = 1'b1;
        cycle();
        clear_inputs();
        chk("t5_in_wait", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        c_resp_valid = 1'b1;
        c_resp_rdata = 8'hEE;
        #1;
        chk("t5_async_busy", busy, 1'b0);
        chk("t5_async_owner", owner, 1'b0);
        chk("t5_async_m1_resp", resp_valid[1], 1'b0);
        chk("t5_async_cv", c_req_valid, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        eval();
        chk("t5_ignored_m1_resp", resp_valid[1], 1'b0);
        chk("t5_ignored_m0_resp", resp_valid[0], 1'b0);
        advance();
        c_resp_valid = 1'b0;

`ifdef DCACHE_ARB_STATS_EN
        // 300 back-to-back m1 transactions saturate its counter.
        do_reset();
        set_req(1, 8'h90, 1'b0, 8'h00);
        c_req_ready = 1'b1;
        c_resp_valid = 1'b1;
        repeat (600) cycle();
        clear_inputs();
        cycle();
        chk("stats_m1_sat", grant_cnt[1], 8'd255);
        chk("stats_m0_zero", grant_cnt[0], 8'd0);
`endif

        // Randomized traffic on both requesters and an erratic cache.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            eval();
            advance();
            for (int i = 0; i < 2; i++) begin
                if (exp_rdy[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(i, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                                8'($urandom_range(0, 255)));
                    else
                        req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                            8'($urandom_range(0, 255)));
                    req_size[i] = 3'($urandom_range(0, 7));
                end
            end
            c_req_ready  = ($urandom_range(0, 3) != 0);
            c_resp_valid = ($urandom_range(0, 2) == 0);
            c_resp_rdata = 8'($urandom_range(0, 255));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
